// File: rtl/hlsm_cond_dp_if.sv
// Start/Done handshake plus operand and result buses shared by the
// controller (master) and the hlsm_cond_dp datapath (slave).
interface hlsm_cond_dp_if #(
    parameter int DATAWIDTH = 32
);
    logic                        Start;
    logic signed [DATAWIDTH-1:0] a;
    logic signed [DATAWIDTH-1:0] b;
    logic signed [DATAWIDTH-1:0] c;
    logic signed [DATAWIDTH-1:0] zero;
    logic signed [DATAWIDTH-1:0] one;
    logic                        t;
    logic                        Done;
    logic signed [DATAWIDTH-1:0] x;
    logic signed [DATAWIDTH-1:0] z;

    modport master (
        output Start, a, b, c, zero, one, t,
        input  Done, x, z
    );

    modport slave (
        input  Start, a, b, c, zero, one, t,
        output Done, x, z
    );
endinterface

// File: rtl/hlsm_cond_dp.sv
// Scheduled HLSM datapath: operands captured at Start, then either a short
// add/sub branch or a multi-cycle multiply branch, with a one-cycle Done pulse.
module hlsm_cond_dp #(
    parameter int DATAWIDTH = 32,
    parameter int MUL_LAT   = 2
) (
    input logic           Clk,
    input logic           Rst,
    hlsm_cond_dp_if.slave bus
);
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_S0    = 3'd1;
    localparam logic [2:0] S_T1    = 3'd2;
    localparam logic [2:0] S_T2    = 3'd3;
    localparam logic [2:0] S_F1    = 3'd4;
    localparam logic [2:0] S_F2    = 3'd5;
    localparam logic [2:0] S_F3    = 3'd6;
    localparam logic [2:0] S_FINAL = 3'd7;

    logic [2:0]                  state;
    logic [CW-1:0]               cnt;
    logic                        ti;
    logic                        done_r;
    logic signed [DATAWIDTH-1:0] ai, bi, ci, zi, oi;
    logic signed [DATAWIDTH-1:0] d, d2, f, g, e;
    logic signed [DATAWIDTH-1:0] x_r, z_r;

    // Low half of the full-precision product; the upper half is discarded.
    function automatic logic signed [DATAWIDTH-1:0] mul_lo(
        input logic signed [DATAWIDTH-1:0] p,
        input logic signed [DATAWIDTH-1:0] q
    );
        logic signed [2*DATAWIDTH-1:0] full;
        full = p * q;
        return $signed(full[DATAWIDTH-1:0]);
    endfunction

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= S_WAIT;
            cnt    <= '0;
            ti     <= 1'b0;
            done_r <= 1'b0;
            ai     <= '0;
            bi     <= '0;
            ci     <= '0;
            zi     <= '0;
            oi     <= '0;
            d      <= '0;
            d2     <= '0;
            f      <= '0;
            g      <= '0;
            e      <= '0;
            x_r    <= '0;
            z_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (bus.Start) begin
                        ai    <= bus.a;
                        bi    <= bus.b;
                        ci    <= bus.c;
                        zi    <= bus.zero;
                        oi    <= bus.one;
                        ti    <= bus.t;
                        state <= S_S0;
                    end
                end
                S_S0: begin
                    d <= ai + bi;
                    if (ti) begin
                        state <= S_T1;
                    end else begin
                        cnt   <= '0;
                        state <= S_F1;
                    end
                end
                S_T1: begin
                    d2    <= ai - oi;
                    f     <= ai + ci;
                    state <= S_T2;
                end
                S_T2: begin
                    x_r   <= f - d2;
                    z_r   <= d;
                    state <= S_FINAL;
                end
                // Multiplier result is re-registered every cycle; only the last one matters.
                S_F1: begin
                    g   <= mul_lo(ai, bi);
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_F2;
                end
                S_F2: begin
                    e     <= g - ci;
                    state <= S_F3;
                end
                S_F3: begin
                    x_r   <= e;
                    z_r   <= d + zi;
                    state <= S_FINAL;
                end
                S_FINAL: begin
                    done_r <= 1'b1;
                    state  <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign bus.Done = done_r;
    assign bus.x    = x_r;
    assign bus.z    = z_r;
endmodule
